mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer placed in front of the single-ported unified Memory of the processor.
- The instruction-fetch port and the load/store port share one memory, one transaction at a time.
- Round-robin grant, registered one-cycle ack/data response per transaction, and a wait-state watchdog for slow memories.
- Sits between the core and Memory; the mem_* side connects directly to Memory's rd_en_i/wr_en_i/addr_i/data_i/data_o/ack_o.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- MAX_WAIT, 15, max cycles in ACCESS without mem_ack_i before forced error completion (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- if_req_i  input  1  instruction fetch request (read only), held until if_ack_o
- if_addr_i  input  ADDR_WIDTH  fetch address
- if_data_o  output  DATA_WIDTH  fetched word, valid with if_ack_o
- if_ack_o  output  1  one-cycle fetch completion pulse
- ls_rd_en_i  input  1  load request, held until ls_ack_o
- ls_wr_en_i  input  1  store request, held until ls_ack_o
- ls_addr_i  input  ADDR_WIDTH  load/store address
- ls_data_i  input  DATA_WIDTH  store data
- ls_data_o  output  DATA_WIDTH  load data, valid with ls_ack_o
- ls_ack_o  output  1  one-cycle load/store completion pulse
- err_o  output  1  pulses with an ack when that transaction timed out
- mem_rd_en_o  output  1  to Memory rd_en_i
- mem_wr_en_o  output  1  to Memory wr_en_i
- mem_addr_o  output  ADDR_WIDTH  to Memory addr_i
- mem_data_o  output  DATA_WIDTH  to Memory data_i
- mem_data_i  input  DATA_WIDTH  from Memory data_o
- mem_ack_i  input  1  from Memory ack_o

Behaviour:
- Reset:
  - rst_n low at a clk edge forces state IDLE, last_grant=LS, and the wait counter to 0.
  - if_ack_o, ls_ack_o, err_o, all mem_* outputs, if_data_o and ls_data_o are all 0.
  - Reset mid-transaction drops it silently: no ack, and no memory write after the reset edge.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: all mem_* enables low.
  - If neither requester is pending, stay.
  - If one is pending, grant it. If both are pending, grant the one not equal to last_grant.
  - Register the grant (owner, addr, wdata, we) and update last_grant. Go to ACCESS.
- ACCESS: mem_addr_o/mem_data_o come from the latched request.
  - Fetch drives mem_rd_en_o=1. Load drives mem_rd_en_o=1. Store drives mem_wr_en_o=1.
  - If ls_rd_en_i and ls_wr_en_i are both high, the transaction is a store.
  - On mem_ack_i=1: latch mem_data_i into the owner's data_o (stores leave ls_data_o unchanged) and go to RESP.
  - Otherwise increment the wait counter. When it reaches MAX_WAIT, set the timeout flag and go to RESP without latching data.
  - A held write enable during wait states is intentional; repeated writes of the same data are idempotent.
- RESP: all mem_* enables low.
  - The owner's ack pulses high exactly one cycle; err_o equals the timeout flag.
  - Clear the wait counter and timeout flag, then return to IDLE.
- Requests sampled while in ACCESS/RESP are ignored. The requester drops its request on the edge after it sees ack, so IDLE never re-grants a completed request.
- Latency with zero-wait memory: request seen in IDLE at cycle 0, ACCESS at cycle 1, ack at cycle 2. Throughput is one transaction per 3 cycles.
- if_data_o/ls_data_o hold their last value between acks.
- Both acks are never high in the same cycle.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/RESP), owner encoding (OWN_IF/OWN_LS), NOP constant 32'h00000013 for bench memory fill.
- One natural sub-module: rr_arbiter2, a 2-way round-robin pick with a last_grant register and an update-enable input.

Test Plan:
1. Reset, then if_req_i=1, if_addr_i=0x8 with Memory word 2 = 0x00500093 -> if_ack_o at cycle 2, if_data_o=0x00500093, err_o=0.
2. Store ls_wr_en_i=1, addr 0x40, data 0xDEADBEEF, then load from 0x40 -> mem_wr_en_o high exactly one cycle; load returns 0xDEADBEEF.
3. if_req_i and ls_rd_en_i held together continuously from reset -> grant order IF, LS, IF, LS; acks are never simultaneous.
4. Memory model with mem_ack_i delayed 3 cycles -> ack at cycle 5, correct data; with mem_ack_i stuck low -> ack after MAX_WAIT=15 ACCESS cycles with err_o=1.
5. rst_n low during ACCESS of a store to 0x10 (old value 0x13) -> no ack; word 0x10 still 0x13 if the reset edge precedes the write edge; all outputs 0 next cycle.
6. ls_rd_en_i and ls_wr_en_i both high -> treated as a store; mem_rd_en_o stays 0 and ls_data_o is unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rtl/mem_port_arbiter_rr_arbiter2.sv - two-way round-robin pick with last-grant memory
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output owner_e     grant_o,
    output logic       valid_o
);

    owner_e last_q;
    owner_e last_d;

    assign valid_o = |req_i;

    always_comb begin
        grant_o = OWN_LS;
        if (req_i[0] && req_i[1]) begin
            grant_o = (last_q == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (req_i[0]) begin
            grant_o = OWN_IF;
        end
        last_d = (update_i && valid_o) ? grant_o : last_q;
    end

    // Reset to LS so that the fetch port wins the first contended cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OWN_LS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store sequencer in front of the unified memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_data_o,
    output logic                  if_ack_o,
    input  logic                  ls_rd_en_i,
    input  logic                  ls_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_data_i,
    output logic [DATA_WIDTH-1:0] ls_data_o,
    output logic                  ls_ack_o,
    output logic                  err_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]            state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] if_data_q, if_data_d;
    logic [DATA_WIDTH-1:0] ls_data_q, ls_data_d;

    logic   ls_req;
    logic   grant_valid;
    owner_e grant;

    assign ls_req = ls_rd_en_i | ls_wr_en_i;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({ls_req, if_req_i}),
        .update_i (state_q == ST_IDLE),
        .grant_o  (grant),
        .valid_o  (grant_valid)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        if_data_d = if_data_q;
        ls_data_d = ls_data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant;
                    addr_d  = (grant == OWN_IF) ? if_addr_i : ls_addr_i;
                    wdata_d = ls_data_i;
                    // Write wins when a requester raises both enables.
                    we_d    = (grant == OWN_LS) && ls_wr_en_i;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    if (owner_q == OWN_IF) begin
                        if_data_d = mem_data_i;
                    end else if (!we_q) begin
                        ls_data_d = mem_data_i;
                    end
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                wait_d  = '0;
                tmo_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            wait_q    <= '0;
            tmo_q     <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
        end
    end

    assign mem_rd_en_o = (state_q == ST_ACCESS) && !we_q;
    assign mem_wr_en_o = (state_q == ST_ACCESS) && we_q;
    assign mem_addr_o  = (state_q == ST_ACCESS) ? addr_q : '0;
    assign mem_data_o  = (state_q == ST_ACCESS) ? wdata_q : '0;

    assign if_ack_o  = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign ls_ack_o  = (state_q == ST_RESP) && (owner_q == OWN_LS);
    assign err_o     = (state_q == ST_RESP) && tmo_q;
    assign if_data_o = if_data_q;
    assign ls_data_o = ls_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        ls_rd, ls_wr;
    logic [31:0] ls_addr, ls_wdata;
    logic [31:0] ls_data_o;
    logic        ls_ack_o, err_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_ack_i;

    logic [31:0] mem [0:255];
    int          mem_delay = 0;
    int          mem_cnt = 0;
    int          rd_cyc = 0;
    int          wr_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        bit          err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_data_o   (if_data_o),
        .if_ack_o    (if_ack_o),
        .ls_rd_en_i  (ls_rd),
        .ls_wr_en_i  (ls_wr),
        .ls_addr_i   (ls_addr),
        .ls_data_i   (ls_wdata),
        .ls_data_o   (ls_data_o),
        .ls_ack_o    (ls_ack_o),
        .err_o       (err_o),
        .mem_rd_en_o (mem_rd_en_o),
        .mem_wr_en_o (mem_wr_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    // Memory model: acks after mem_delay enabled cycles, writes on its ack edge.
    assign mem_ack_i  = (mem_rd_en_o || mem_wr_en_o) && (mem_cnt == mem_delay);
    assign mem_data_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_rd_en_o || mem_wr_en_o) mem_cnt <= mem_cnt + 1;
        else                            mem_cnt <= 0;
        if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[9:2]] <= mem_data_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_rd_en_o) rd_cyc <= rd_cyc + 1;
        if (mem_wr_en_o) wr_cyc <= wr_cyc + 1;
        if (if_ack_o || ls_ack_o) chk("ack_exclusive", {63'd0, if_ack_o & ls_ack_o}, 64'd0);
    end

    task automatic drop_reqs();
        if_req = 1'b0; ls_rd = 1'b0; ls_wr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {63'd0, |{if_ack_o, ls_ack_o, err_o, mem_rd_en_o, mem_wr_en_o,
                           mem_addr_o, mem_data_o, if_data_o, ls_data_o}}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_reqs();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;
    endtask

    // Called at posedge+1 with the DUT idle; the request is visible in cycle 0.
    task automatic txn(input bit is_if, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input bit exp_err, input int exp_lat);
        exp_t e;
        int   lat;
        bit   got;
        e.is_if = is_if; e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
        sb.push_back(e);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_rd = rd; ls_wr = wr; ls_addr = addr; ls_wdata = wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (if_ack_o || ls_ack_o) got = 1'b1;
        end
        chk("ack_seen", {63'd0, got}, 64'd1);
        if (got) begin
            e = sb.pop_front();
            chk("ack_owner", {63'd0, if_ack_o}, {63'd0, e.is_if});
            chk("ack_data", {32'd0, e.is_if ? if_data_o : ls_data_o}, {32'd0, e.data});
            chk("ack_err", {63'd0, err_o}, {63'd0, e.err});
            chk("ack_latency", 64'(lat), 64'(e.lat));
        end else begin
            sb.delete();
        end
        drop_reqs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP_INSTR;
        mem[2] = 32'h0050_0093;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        do_reset();

        // Fetch with zero-wait memory.
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0050_0093, 1'b0, 2);

        // Store then load back; the store must leave ls_data_o at its reset value.
        wr_cyc = 0;
        txn(1'b0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        chk("store_wr_cycles", 64'(wr_cyc), 64'd1);
        txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // Both requesters held from reset: IF, LS, IF, LS at cycles 2, 5, 8, 11.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.is_if = (k % 2 == 0);
            e.data  = e.is_if ? 32'h0050_0093 : 32'hDEAD_BEEF;
            e.err   = 1'b0;
            e.lat   = 2 + 3 * k;
            sb.push_back(e);
        end
        if_req = 1'b1; if_addr = 32'h8;
        ls_rd = 1'b1; ls_addr = 32'h40;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (if_ack_o || ls_ack_o) begin
                if (sb.size() == 0) begin
                    chk("rr_extra_ack", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rr_owner", {63'd0, if_ack_o}, {63'd0, e.is_if});
                    chk("rr_data", {32'd0, e.is_if ? if_data_o : ls_data_o}, {32'd0, e.data});
                    chk("rr_cycle", 64'(c), 64'(e.lat));
                end
            end
        end
        chk("rr_all_acked", 64'(sb.size()), 64'd0);
        sb.delete();
        drop_reqs();
        @(posedge clk);
        #1;

        // Three wait states, then a stuck memory that must time out holding old data.
        mem_delay = 3;
        txn(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0050_0093, 1'b0, 5);
        mem_delay = 1000;
        txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0050_0093, 1'b1, 16);
        mem_delay = 0;
        txn(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // Reset lands in ACCESS before the slow memory's write edge.
        mem_delay = 3;
        ls_wr = 1'b1; ls_addr = 32'h10; ls_wdata = 32'hCAFE_F00D;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_no_ack", {62'd0, if_ack_o, ls_ack_o}, 64'd0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("abort_outputs");
        chk("abort_mem_kept", {32'd0, mem[4]}, {32'd0, NOP_INSTR});
        ls_wr = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("abort_quiet", {61'd0, if_ack_o, ls_ack_o, mem_wr_en_o}, 64'd0);
        end
        chk("abort_mem_final", {32'd0, mem[4]}, {32'd0, NOP_INSTR});
        mem_delay = 0;
        txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, NOP_INSTR, 1'b0, 2);

        // Read and write enables together behave as a store.
        rd_cyc = 0;
        txn(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, NOP_INSTR, 1'b0, 2);
        chk("dual_no_read", 64'(rd_cyc), 64'd0);
        chk("dual_mem_written", {32'd0, mem[8]}, 64'h1234_5678);
        txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
